// File: rtl/snake_input_ctrl.sv
// Purpose: sync/debounce four buttons, turn presses into one committed direction, pace moves.
// Latency: raw press -> BtnPulse after DB_CYCLES+3 edges; pending -> Dir on the edge ending MoveTick.
// Backpressure: none; pulses are single-cycle and never stall, and the latest accepted request wins.
module snake_input_ctrl #(
  parameter int DB_CYCLES   = 500000,
  parameter int MOVE_PERIOD = 10000000,
  parameter int CNT_W       = 24
) (
  input  logic       ClkPort,
  input  logic       Reset_n,
  input  logic       BtnL,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnR,
  input  logic       Run,
  output logic [1:0] Dir,
  output logic       MoveTick,
  output logic       DirChanged,
  output logic [3:0] BtnPulse
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(MOVE_PERIOD - 1);

  // Bit order {U, D, L, R} matches BtnPulse.
  logic [3:0]       btn_raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       db_lvl;
  logic [3:0]       db_prev;
  logic [CNT_W-1:0] db_cnt [4];
  logic [CNT_W-1:0] tick_cnt;
  logic             pend_vld;
  logic [1:0]       pend_dir;
  logic             req_vld;
  logic [1:0]       req_dir;
  logic             req_ok;
  logic             commit;

  assign btn_raw = {BtnU, BtnD, BtnL, BtnR};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: level flips only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      db_lvl <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered rising-edge detect on the debounced levels; releases give no pulse.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      db_prev  <= '0;
      BtnPulse <= '0;
    end else begin
      db_prev  <= db_lvl;
      BtnPulse <= db_lvl & ~db_prev;
    end
  end

  // Priority U > D > L > R; reject a request equal or opposite to the committed direction.
  always_comb begin
    req_vld = |BtnPulse;
    req_dir = 2'b00;
    if (BtnPulse[3])      req_dir = 2'b01;
    else if (BtnPulse[2]) req_dir = 2'b11;
    else if (BtnPulse[1]) req_dir = 2'b10;
    else                  req_dir = 2'b00;
    req_ok  = req_vld && (req_dir != Dir) && (req_dir != (Dir ^ 2'b10));
    commit  = MoveTick && pend_vld;
  end

  // Move tick counter: counts only while running, pulses on the cycle after a wrap.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      tick_cnt <= '0;
      MoveTick <= 1'b0;
    end else if (!Run) begin
      tick_cnt <= '0;
      MoveTick <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      MoveTick <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
      MoveTick <= 1'b0;
    end
  end

  // Pending request and committed direction; a request landing on a commit edge waits a tick.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      Dir      <= 2'b00;
      pend_vld <= 1'b0;
      pend_dir <= 2'b00;
    end else if (!Run) begin
      Dir      <= 2'b00;
      pend_vld <= 1'b0;
    end else begin
      if (commit) Dir <= pend_dir;
      if (req_ok) begin
        pend_vld <= 1'b1;
        pend_dir <= req_dir;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Flags the tick cycle whose closing edge loads a new direction.
  assign DirChanged = commit;

endmodule
